pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the single-issue MIPS datapath. It computes the `Address` input of the `ProgramCounter` register every cycle. It arbitrates among sequential fetch, branch, jump and jump-register redirects, and holds the PC on pipeline stalls and on instruction-memory wait. It also parks the PC on halt and emits a one-cycle `Flush` to the front-end pipeline registers on every applied redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value driven during and immediately after reset
- `EXC_VECTOR`, 32'h0000_0080, redirect target on a misaligned target; used only when checking is compiled in
- `Clk` in 1: rising-edge clock; the only clock.
- `Reset` in 1: synchronous, active-low; sampled on `Clk` rising edge.
- `PCResult` in 32: current PC from `ProgramCounter`.
- `Address` out 32: next PC, combinational; loaded by `ProgramCounter` each edge.
- `Stall` in 1: hazard unit requests that the PC be held.
- `IMemReady` in 1: instruction memory has returned the word at `PCResult`.
- `BranchTaken` in 1 and `BranchTarget` in 32: resolved taken branch.
- `Jump` in 1 and `JumpIndex` in 26: j/jal; target is {`PCResult`+4 [31:28], `JumpIndex`, 2'b00}.
- `JumpReg` in 1 and `JumpRegTarget` in 32: jr/jalr.
- `Halt` in 1: break/syscall-halt retired. `Resume` in 1: leave halt.
- `Flush` out 1: registered one-cycle pulse after an applied redirect.
- `Halted` out 1: high while in HALT.
- `AddrErr` out 1: registered one-cycle pulse on a misaligned target; present only with the macro.

## Operation
- FSM states: RESET, RUN, HALT.
  - RESET: entered when `Reset`=0. `Address`=`RESET_PC`. Pending cleared. All outputs low. Moves to RUN on the first edge with `Reset`=1.
  - RUN: `Address` is chosen by the priority below.
  - HALT: `Address`=`PCResult`, `Halted`=1. Redirect inputs are ignored. `Resume`=1 moves to RUN with `Address`=`PCResult`+4.
- RUN priority, highest first:
  1. `Halt` sends the FSM to HALT; `Address`=`PCResult`.
  2. Redirect select is `JumpReg` > `Jump` > `BranchTaken`.
  3. If a redirect is present, or pending, and `IMemReady`=1: `Address`=target, and `Flush` pulses next cycle. Redirect overrides `Stall`.
  4. If a redirect arrives with `IMemReady`=0: the target is latched into the pending register and `Address`=`PCResult`.
  5. Otherwise, if `Stall`=1 or `IMemReady`=0: `Address`=`PCResult`.
  6. Otherwise: `Address`=`PCResult`+4.
- Pending register:
  - Holds one target plus a valid bit.
  - The first redirect wins: a new redirect is ignored while pending is valid, because the older instruction flushes the younger one.
  - Cleared when its target is applied, and on reset.
  - `Halt` takes priority and clears pending.
- Arithmetic: 32-bit unsigned; +4 wraps 32'hFFFF_FFFC→32'h0000_0000 with no flag.

## Timing
- Combinational path from inputs to `Address`, zero latency. The PC update is visible on `PCResult` one edge later.
- `Flush`, `Halted` and `AddrErr` are registered. `Flush` is high for exactly one cycle, on the cycle after the redirect edge.
- Reset: `Address`=`RESET_PC` and all other outputs 0 from the first edge with `Reset`=0. Reset mid-redirect discards pending and suppresses `Flush`.
- `Halt` and a redirect in the same cycle: `Halt` wins and pending is cleared.
- `Resume` in RUN has no effect.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A selected target with bits [1:0]≠0 is replaced by `EXC_VECTOR`.
  - `AddrErr` pulses one cycle and `Flush` pulses as normal.
- `PC_ALIGN_CHECK_EN` undefined:
  - No check is made; the target passes unmodified.
  - The `AddrErr` port is absent.

## Structure
- Shared package `pc_pkg`:
  - state encoding (RESET=2'b00, RUN=2'b01, HALT=2'b10)
  - `PC_INC`=4
  - default `RESET_PC` and `EXC_VECTOR`
- Sub-module `pc_target_mux`: combinational redirect priority select and jump-target formation. It outputs `redir_valid` and `redir_target`. The FSM and pending register stay in `pc_sequencer`.

## Test plan
- Reset=0 for 2 cycles, then 1, with `IMemReady`=1 → `Address` 0,0 then 4,8,12,16 on consecutive cycles; `Flush`=0.
- At PC=8, `Stall`=1 for 3 cycles → PC holds at 8 for 3 cycles, then 12.
- At PC=12, `JumpReg`=1 (0x40) together with `BranchTaken`=1 (0x80) → next PC 0x40, `Flush` high one cycle, then 0x44.
- At PC=16, `IMemReady`=0 for 2 cycles; `Jump` with index 0x10 arrives in the first cycle and `BranchTaken` (0x200) in the second → PC holds 16; when ready returns, PC=0x40 and the branch is ignored.
- `Halt` at PC=0x20 → `Halted`=1 and PC holds at 0x20 for 5 cycles; `Resume` → PC=0x24; `Reset`=0 mid-HALT → `Address`=`RESET_PC`.
- With `PC_ALIGN_CHECK_EN`: `BranchTarget`=0x102 → PC=0x80, `AddrErr` and `Flush` each pulse one cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC sequencer: FSM encoding, PC increment and default vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } pc_state_t;

  localparam logic [31:0] PC_INC             = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Datapath-side bus of the next-PC sequencer; AddrErr exists only with PC_ALIGN_CHECK_EN.
interface pc_sequencer_if;
  logic [31:0] PCResult;
  logic [31:0] Address;
  logic        Stall;
  logic        IMemReady;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] JumpRegTarget;
  logic        Halt;
  logic        Resume;
  logic        Flush;
  logic        Halted;
`ifdef PC_ALIGN_CHECK_EN
  logic        AddrErr;

  modport master (
    output PCResult, Stall, IMemReady, BranchTaken, BranchTarget, Jump, JumpIndex,
           JumpReg, JumpRegTarget, Halt, Resume,
    input  Address, Flush, Halted, AddrErr
  );

  modport slave (
    input  PCResult, Stall, IMemReady, BranchTaken, BranchTarget, Jump, JumpIndex,
           JumpReg, JumpRegTarget, Halt, Resume,
    output Address, Flush, Halted, AddrErr
  );
`else
  modport master (
    output PCResult, Stall, IMemReady, BranchTaken, BranchTarget, Jump, JumpIndex,
           JumpReg, JumpRegTarget, Halt, Resume,
    input  Address, Flush, Halted
  );

  modport slave (
    input  PCResult, Stall, IMemReady, BranchTaken, BranchTarget, Jump, JumpIndex,
           JumpReg, JumpRegTarget, Halt, Resume,
    output Address, Flush, Halted
  );
`endif
endinterface

// File: rtl/pc_target_mux.sv
// Redirect priority select (JumpReg > Jump > BranchTaken) and j/jal target formation.
module pc_target_mux
  import pc_pkg::*;
(
  input  logic [31:0] PCResult,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  logic [3:0]  region;
  logic [31:0] jump_target;

  // j/jal stays inside the 256 MB region of the delay-slot address
  assign region      = 4'((PCResult + PC_INC) >> 28);
  assign jump_target = {region, JumpIndex, 2'b00};

  always_comb begin
    redir_valid  = JumpReg | Jump | BranchTaken;
    redir_target = BranchTarget;
    if (JumpReg) begin
      redir_target = JumpRegTarget;
    end else if (Jump) begin
      redir_target = jump_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: reset/run/halt FSM, one-deep pending redirect, Flush pulse.
// Optional misaligned-target trap to EXC_VECTOR with AddrErr when PC_ALIGN_CHECK_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
`endif
) (
  input logic            Clk,
  input logic            Reset,
  pc_sequencer_if.slave  bus
);

  pc_state_t   state_reg, state_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic        flush_reg, flush_next;
  logic        halted_reg, halted_next;
  logic        addr_err_next;
  logic [31:0] address;

  logic        redir_valid;
  logic [31:0] redir_target;
  logic        sel_valid;
  logic [31:0] sel_target;
  logic [31:0] apply_target;
  logic        apply_bad;

  pc_target_mux u_target_mux (
    .PCResult      (bus.PCResult),
    .BranchTaken   (bus.BranchTaken),
    .BranchTarget  (bus.BranchTarget),
    .Jump          (bus.Jump),
    .JumpIndex     (bus.JumpIndex),
    .JumpReg       (bus.JumpReg),
    .JumpRegTarget (bus.JumpRegTarget),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target)
  );

  // The oldest redirect wins: a pending target shadows anything arriving later
  assign sel_valid  = pend_valid_reg | redir_valid;
  assign sel_target = pend_valid_reg ? pend_target_reg : redir_target;

`ifdef PC_ALIGN_CHECK_EN
  assign apply_bad    = misaligned(sel_target[1:0]);
  assign apply_target = apply_bad ? EXC_VECTOR : sel_target;
`else
  assign apply_bad    = 1'b0;
  assign apply_target = sel_target;
`endif

  always_comb begin
    state_next       = state_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    flush_next       = 1'b0;
    addr_err_next    = 1'b0;
    address          = bus.PCResult;

    unique case (state_reg)
      ST_RESET: begin
        address         = RESET_PC;
        pend_valid_next = 1'b0;
        state_next      = ST_RUN;
      end
      ST_RUN: begin
        if (bus.Halt) begin
          state_next      = ST_HALT;
          pend_valid_next = 1'b0;
        end else if (sel_valid && bus.IMemReady) begin
          address         = apply_target;
          flush_next      = 1'b1;
          addr_err_next   = apply_bad;
          pend_valid_next = 1'b0;
        end else if (sel_valid) begin
          if (!pend_valid_reg) begin
            pend_valid_next  = 1'b1;
            pend_target_next = redir_target;
          end
        end else if (!bus.Stall && bus.IMemReady) begin
          address = bus.PCResult + PC_INC;
        end
      end
      ST_HALT: begin
        if (bus.Resume) begin
          state_next = ST_RUN;
          address    = bus.PCResult + PC_INC;
        end
      end
      default: begin
        address         = RESET_PC;
        pend_valid_next = 1'b0;
        state_next      = ST_RESET;
      end
    endcase

    if (!Reset) begin
      state_next      = ST_RESET;
      address         = RESET_PC;
      pend_valid_next = 1'b0;
      flush_next      = 1'b0;
      addr_err_next   = 1'b0;
    end

    halted_next = (state_next == ST_HALT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg       <= ST_RESET;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'h0;
      flush_reg       <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      flush_reg       <= flush_next;
      halted_reg      <= halted_next;
    end
  end

  assign bus.Address = address;
  assign bus.Flush   = flush_reg;
  assign bus.Halted  = halted_reg;

`ifdef PC_ALIGN_CHECK_EN
  logic addr_err_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= addr_err_next;
    end
  end

  assign bus.AddrErr = addr_err_reg;
`else
  logic unused_addr_err;
  assign unused_addr_err = addr_err_next;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; also covers the AddrErr path when PC_ALIGN_CHECK_EN is defined.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        halted;
    logic        addr_err;
  } exp_t;

  exp_t exp_q[$];

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] ALIGN_EXP = 32'h0000_0080;
  localparam logic        AERR_EXP  = 1'b1;
`else
  localparam logic [31:0] ALIGN_EXP = 32'h0000_0102;
  localparam logic        AERR_EXP  = 1'b0;
`endif

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ProgramCounter model: loads Address on every rising edge
  always @(posedge clk) bus.PCResult <= bus.Address;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", tag, step_no, got, exp);
    end
  endtask

  task automatic idle();
    bus.Stall         = 1'b0;
    bus.IMemReady     = 1'b1;
    bus.BranchTaken   = 1'b0;
    bus.BranchTarget  = 32'h0;
    bus.Jump          = 1'b0;
    bus.JumpIndex     = 26'h0;
    bus.JumpReg       = 1'b0;
    bus.JumpRegTarget = 32'h0;
    bus.Halt          = 1'b0;
    bus.Resume        = 1'b0;
  endtask

  task automatic step(input logic [31:0] e_addr, input logic e_flush, input logic e_halted,
                      input logic e_aerr = 1'b0);
    exp_t e;
    exp_q.push_back('{addr: e_addr, flush: e_flush, halted: e_halted, addr_err: e_aerr});
    @(negedge clk);
    step_no++;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("address", bus.Address, e.addr);
      check_val("flush", {31'b0, bus.Flush}, {31'b0, e.flush});
      check_val("halted", {31'b0, bus.Halted}, {31'b0, e.halted});
`ifdef PC_ALIGN_CHECK_EN
      check_val("addr_err", {31'b0, bus.AddrErr}, {31'b0, e.addr_err});
`endif
    end
    $display("step %0d rst %0b pc %h addr %h flush %0b halted %0b", step_no, rst_n,
             bus.PCResult, bus.Address, bus.Flush, bus.Halted);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.PCResult = 32'h0;
    idle();
    @(posedge clk);
    #1;

    // reset, then sequential fetch
    idle(); step(32'h0, 0, 0);
    idle(); step(32'h0, 0, 0);
    rst_n = 1'b1;
    idle(); step(32'h0, 0, 0);
    idle(); step(32'h4, 0, 0);
    idle(); step(32'h8, 0, 0);

    // stall holds at 8 for three cycles
    repeat (3) begin
      idle(); bus.Stall = 1'b1; step(32'h8, 0, 0);
    end
    idle(); step(32'hC, 0, 0);

    // jr beats a simultaneous branch
    idle(); bus.JumpReg = 1'b1; bus.JumpRegTarget = 32'h40;
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h80;
    step(32'h40, 0, 0);
    idle(); step(32'h44, 1, 0);
    idle(); step(32'h48, 0, 0);

    // jump during imem wait is pending; later branch is ignored
    idle(); bus.IMemReady = 1'b0; bus.Jump = 1'b1; bus.JumpIndex = 26'h10;
    step(32'h48, 0, 0);
    idle(); bus.IMemReady = 1'b0; bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h200;
    step(32'h48, 0, 0);
    idle(); bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h200;
    step(32'h40, 0, 0);
    idle(); step(32'h44, 1, 0);

    // reach 0x20, halt there, ignore redirects, then resume
    idle(); bus.Jump = 1'b1; bus.JumpIndex = 26'h8; step(32'h20, 0, 0);
    idle(); bus.Halt = 1'b1; step(32'h20, 1, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 2) begin
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h300;
      end
      step(32'h20, 0, 1);
    end
    idle(); bus.Resume = 1'b1; step(32'h24, 0, 1);
    idle(); bus.Resume = 1'b1; step(32'h28, 0, 0);

    // halt wins over jr in the same cycle; reset while halted
    idle(); bus.Halt = 1'b1; bus.JumpReg = 1'b1; bus.JumpRegTarget = 32'h400;
    step(32'h28, 0, 0);
    idle(); step(32'h28, 0, 1);
    rst_n = 1'b0;
    idle(); step(32'h0, 0, 1);
    idle(); step(32'h0, 0, 0);
    rst_n = 1'b1;
    idle(); step(32'h0, 0, 0);
    idle(); step(32'h4, 0, 0);

    // misaligned branch target
    idle(); bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h102; step(ALIGN_EXP, 0, 0);
    idle(); step(ALIGN_EXP + 32'd4, 1, 0, AERR_EXP);
    idle(); step(ALIGN_EXP + 32'd8, 0, 0);

    // redirect overrides stall
    idle(); bus.Stall = 1'b1; bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h500;
    step(32'h500, 0, 0);
    idle(); step(32'h504, 1, 0);

    // +4 wraps at the top of the address space
    idle(); bus.JumpReg = 1'b1; bus.JumpRegTarget = 32'hFFFF_FFFC; step(32'hFFFF_FFFC, 0, 0);
    idle(); step(32'h0, 1, 0);
    idle(); step(32'h4, 0, 0);

    // reset discards a pending redirect and its flush
    idle(); bus.IMemReady = 1'b0; bus.JumpReg = 1'b1; bus.JumpRegTarget = 32'h100;
    step(32'h4, 0, 0);
    rst_n = 1'b0;
    idle(); bus.IMemReady = 1'b0; step(32'h0, 0, 0);
    rst_n = 1'b1;
    idle(); step(32'h0, 0, 0);
    idle(); step(32'h4, 0, 0);
    idle(); step(32'h8, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
